axi_err_slave: RTL and testbench

AXI_ERR_SLAVE -- requirements
Module: axi_err_slave

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_err_slave_rd.sv | 64 ++++++
 rtl/axi_err_slave.sv | 132 +++++++++++++
 tb/tb_axi_err_slave.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes and the channel state encodings
// used by the default error slave.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_err_slave_rd.sv
// Read-channel engine of the error slave: accepts one AR at a time and
// returns arlen+1 DECERR beats with zero data.
module axi_err_slave_rd
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    input  logic [ID_WIDTH-1:0]   i_arid,
    input  logic [7:0]            i_arlen,
    output logic                  o_rvalid,
    output logic [1:0]            o_rresp,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rlast,
    output logic [ID_WIDTH-1:0]   o_rid,
    input  logic                  i_rready
);

    r_state_e            r_state;
    logic [7:0]          r_cnt;
    logic [ID_WIDTH-1:0] r_arid;

    // r_cnt holds the beats still owed after the current one, so 255 gives 256 beats
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= R_IDLE;
            r_cnt   <= 8'd0;
            r_arid  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (i_arvalid && o_arready) begin
                        r_state <= R_DATA;
                        r_cnt   <= i_arlen;
                        r_arid  <= i_arid;
                    end
                end
                R_DATA: begin
                    if (i_rready) begin
                        if (r_cnt == 8'd0) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign o_arready = i_en && (r_state == R_IDLE);
    assign o_rvalid  = (r_state == R_DATA);
    assign o_rresp   = o_rvalid ? RESP_DECERR : RESP_OKAY;
    assign o_rdata   = '0;
    assign o_rlast   = o_rvalid && (r_cnt == 8'd0);
    assign o_rid     = r_arid;

endmodule

// File: rtl/axi_err_slave.sv
// Default (unmapped-address) AXI slave: every read and write ends in DECERR.
// Define AXI_ERR_SLAVE_LOG_EN for simulation messages on each accept/response.
module axi_err_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    output logic                    o_bvalid,
    output logic [1:0]              o_bresp,
    output logic [ID_WIDTH-1:0]     o_bid,
    input  logic                    i_bready,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    output logic                    o_rvalid,
    output logic [1:0]              o_rresp,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_rlast,
    output logic [ID_WIDTH-1:0]     o_rid,
    input  logic                    i_rready
);

    logic                  r_rst_done;
    w_state_e              r_wstate;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic                  w_unused;

    // Holds both address channels closed for the first edge after reset release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wstate <= W_IDLE;
            r_awid   <= '0;
            r_awaddr <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (i_awvalid && o_awready) begin
                        r_wstate <= W_DATA;
                        r_awid   <= i_awid;
                        r_awaddr <= i_awaddr;
                    end
                end
                W_DATA: begin
                    // Burst ends on wlast alone; awlen is deliberately not enforced
                    if (i_wvalid && i_wlast) begin
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (i_bready) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign o_awready = r_rst_done && (r_wstate == W_IDLE);
    assign o_wready  = (r_wstate == W_DATA);
    assign o_bvalid  = (r_wstate == W_RESP);
    assign o_bresp   = o_bvalid ? RESP_DECERR : RESP_OKAY;
    assign o_bid     = r_awid;

    axi_err_slave_rd #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_rd (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (r_rst_done),
        .i_arvalid (i_arvalid),
        .o_arready (o_arready),
        .i_arid    (i_arid),
        .i_arlen   (i_arlen),
        .o_rvalid  (o_rvalid),
        .o_rresp   (o_rresp),
        .o_rdata   (o_rdata),
        .o_rlast   (o_rlast),
        .o_rid     (o_rid),
        .i_rready  (i_rready)
    );

    // Payload and burst attributes are accepted but have no effect on behaviour
    assign w_unused = ^{i_awsize, i_awburst, i_arsize, i_arburst, i_wdata,
                        i_wstrb, i_awlen, i_araddr, r_awaddr};

`ifdef AXI_ERR_SLAVE_LOG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (i_awvalid && o_awready)
                $display("axi_err_slave: AW addr=%h id=%0d len=%0d", i_awaddr, i_awid, i_awlen);
            if (i_arvalid && o_arready)
                $display("axi_err_slave: AR addr=%h id=%0d len=%0d", i_araddr, i_arid, i_arlen);
            if (o_bvalid && i_bready)
                $display("axi_err_slave: B DECERR id=%0d addr=%h", o_bid, r_awaddr);
            if (o_rvalid && i_rready && o_rlast)
                $display("axi_err_slave: R DECERR id=%0d complete", o_rid);
        end
    end
`endif

endmodule

// File: tb/tb_axi_err_slave.sv
// Self-checking bench for axi_err_slave: directed scenarios plus random
// concurrent traffic against a transaction-level model of the error slave.
module tb_axi_err_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            awvalid = 1'b0, awready;
    logic [AW-1:0]   awaddr = '0;
    logic [IW-1:0]   awid = '0;
    logic [7:0]      awlen = '0;
    logic [2:0]      awsize = 3'd2, arsize = 3'd2;
    logic [1:0]      awburst = 2'd1, arburst = 2'd1;
    logic            wvalid = 1'b0, wready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '1;
    logic            wlast = 1'b0;
    logic            bvalid, bready = 1'b0;
    logic [1:0]      bresp;
    logic [IW-1:0]   bid;
    logic            arvalid = 1'b0, arready;
    logic [AW-1:0]   araddr = '0;
    logic [IW-1:0]   arid = '0;
    logic [7:0]      arlen = '0;
    logic            rvalid, rlast, rready = 1'b0;
    logic [1:0]      rresp;
    logic [DW-1:0]   rdata;
    logic [IW-1:0]   rid;

    axi_err_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr), .i_awid(awid),
        .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
        .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
        .o_bvalid(bvalid), .o_bresp(bresp), .o_bid(bid), .i_bready(bready),
        .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr), .i_arid(arid),
        .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
        .o_rvalid(rvalid), .o_rresp(rresp), .o_rdata(rdata), .o_rlast(rlast),
        .o_rid(rid), .i_rready(rready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: what the slave owes on each channel
    bit          m_ready_en = 0;
    int          m_rd_left  = 0;
    logic [IW-1:0] m_rd_id  = '0;
    bit          m_wr_open  = 0;
    bit          m_b_owed   = 0;
    logic [IW-1:0] m_wr_id  = '0;

    // Stimulus knobs
    bit          ar_req = 0, aw_req = 0;
    logic [IW-1:0] ar_id = '0, aw_id = '0;
    logic [7:0]  ar_len = '0, aw_len = '0;
    int          w_left = 0;
    bit          w_en = 0, w_rand = 0, w_hold = 0;
    int          rr_mode = 0;
    bit          br_rand = 0;
    int          b_stall = 0;

    // Observed DUT traffic and the totals it should reach
    int dut_rbeats = 0, dut_rlasts = 0, dut_wbeats = 0, dut_bcount = 0;
    int exp_rbeats = 0, exp_rlasts = 0, exp_wbeats = 0, exp_bcount = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, awready, 0);
        chk({tag, "_wready"},  wready,  0);
        chk({tag, "_bvalid"},  bvalid,  0);
        chk({tag, "_arready"}, arready, 0);
        chk({tag, "_rvalid"},  rvalid,  0);
        chk({tag, "_rlast"},   rlast,   0);
        chk({tag, "_bresp"},   bresp,   0);
        chk({tag, "_rresp"},   rresp,   0);
        chk({tag, "_bid"},     bid,     0);
        chk({tag, "_rid"},     rid,     0);
        chk({tag, "_rdata"},   rdata,   0);
    endtask

    task automatic clear_counts();
        dut_rbeats = 0; dut_rlasts = 0; dut_wbeats = 0; dut_bcount = 0;
        exp_rbeats = 0; exp_rlasts = 0; exp_wbeats = 0; exp_bcount = 0;
    endtask

    task automatic start_read(input logic [IW-1:0] id, input logic [7:0] len);
        ar_req = 1; ar_id = id; ar_len = len;
        exp_rbeats += int'(len) + 1;
        exp_rlasts++;
    endtask

    task automatic start_write(input logic [IW-1:0] id, input logic [7:0] len);
        aw_req = 1; aw_id = id; aw_len = len;
        w_left = int'(len) + 1; w_en = 1;
        exp_wbeats += int'(len) + 1;
        exp_bcount++;
    endtask

    // One clock: check outputs, drive inputs for the coming edge, advance the model
    task automatic step();
        bit ex_awready, ex_arready, ar_hs, aw_hs, w_hs, r_hs, b_hs;
        @(negedge clk);
        ex_awready = m_ready_en && !m_wr_open && !m_b_owed;
        ex_arready = m_ready_en && (m_rd_left == 0);
        chk("awready", awready, ex_awready);
        chk("wready",  wready,  m_wr_open);
        chk("bvalid",  bvalid,  m_b_owed);
        if (m_b_owed) begin
            chk("bresp", bresp, 2'b11);
            chk("bid",   bid,   m_wr_id);
        end
        chk("arready", arready, ex_arready);
        chk("rvalid",  rvalid,  m_rd_left != 0);
        if (m_rd_left != 0) begin
            chk("rresp", rresp, 2'b11);
            chk("rdata", rdata, 0);
            chk("rid",   rid,   m_rd_id);
            chk("rlast", rlast, m_rd_left == 1);
        end

        arvalid = ar_req; arid = ar_id; arlen = ar_len;
        araddr  = $urandom;
        awvalid = aw_req; awid = aw_id; awlen = aw_len;
        awaddr  = $urandom;
        if (!w_hold) begin
            w_hold = (w_left > 0) && w_en && (!w_rand || $urandom_range(0, 3) != 0);
            wdata  = $urandom;
        end
        wvalid = w_hold;
        wlast  = (w_left == 1);
        case (rr_mode)
            0:       rready = 1'b1;
            1:       rready = ~rready;
            default: rready = 1'($urandom_range(0, 1));
        endcase
        if (m_b_owed && b_stall > 0) begin
            bready = 1'b0;
            b_stall--;
        end else begin
            bready = br_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end

        if (rvalid && rready) begin
            dut_rbeats++;
            if (rlast) dut_rlasts++;
        end
        if (wvalid && wready) dut_wbeats++;
        if (bvalid && bready) dut_bcount++;

        ar_hs = arvalid && ex_arready;
        r_hs  = (m_rd_left != 0) && rready;
        aw_hs = awvalid && ex_awready;
        w_hs  = wvalid && m_wr_open;
        b_hs  = m_b_owed && bready;
        if (ar_hs) begin
            m_rd_left = int'(ar_len) + 1;
            m_rd_id   = ar_id;
            ar_req    = 0;
        end
        if (r_hs) m_rd_left--;
        if (aw_hs) begin
            m_wr_open = 1;
            m_wr_id   = aw_id;
            aw_req    = 0;
        end
        if (w_hs) begin
            w_left--;
            w_hold = 0;
            if (wlast) begin
                m_wr_open = 0;
                m_b_owed  = 1;
            end
        end
        if (b_hs) m_b_owed = 0;
        m_ready_en = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0; rready = 0; bready = 0;
        ar_req = 0; aw_req = 0; w_left = 0; w_en = 0; w_hold = 0; b_stall = 0;
        m_ready_en = 0; m_rd_left = 0; m_rd_id = '0;
        m_wr_open = 0; m_b_owed = 0; m_wr_id = '0;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        chk_all_zero("rst_held");
        rst_n = 1'b1;
        // The first edge after release sets rst_done; no handshake can occur on it
        m_ready_en = 1;
    endtask

    task automatic run_until_idle(input int budget);
        int left = budget;
        while ((ar_req || aw_req || w_left > 0 || m_rd_left != 0 || m_wr_open || m_b_owed) && left > 0) begin
            step();
            left--;
        end
        chk("idle_in_budget", {ar_req, aw_req, m_wr_open, m_b_owed, 32'(m_rd_left), 8'(w_left)}, 0);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_rbeats"}, dut_rbeats, exp_rbeats);
        chk({tag, "_rlasts"}, dut_rlasts, exp_rlasts);
        chk({tag, "_wbeats"}, dut_wbeats, exp_wbeats);
        chk({tag, "_bcount"}, dut_bcount, exp_bcount);
    endtask

    initial begin
        int budget;
        logic [7:0] ln;
        logic [7:0] wl;

        // Reset state and ready rise one cycle after release
        do_reset();
        clear_counts();

        // Single-beat read, ID 5
        rr_mode = 0;
        start_read(4'h5, 8'd0);
        run_until_idle(20);
        check_counts("read1");
        step();

        // Four-beat read with rready toggling
        clear_counts();
        rr_mode = 1;
        start_read(4'($urandom), 8'd3);
        run_until_idle(40);
        check_counts("read4");

        // Write ID A, 3 beats, bready low 5 cycles
        clear_counts();
        w_rand = 0; br_rand = 0; b_stall = 5;
        start_write(4'hA, 8'd2);
        run_until_idle(40);
        check_counts("write3");

        // W beats presented before AW
        clear_counts();
        w_left = 2; w_en = 1; w_rand = 0;
        aw_id = 4'h3; aw_len = 8'd1;
        exp_wbeats = 2; exp_bcount = 1;
        for (int i = 0; i < 3; i++) step();
        chk("w_early_blocked", dut_wbeats, 0);
        aw_req = 1;
        run_until_idle(40);
        check_counts("w_early");

        // Concurrent read (8 beats) and write burst
        clear_counts();
        rr_mode = 2; br_rand = 1; w_rand = 1;
        start_read(4'($urandom), 8'd7);
        start_write(4'($urandom), 8'($urandom_range(0, 15)));
        run_until_idle(400);
        check_counts("concurrent");

        // Reset in the middle of an 8-beat read
        clear_counts();
        rr_mode = 0;
        start_read(4'h9, 8'd7);
        budget = 30;
        while (dut_rbeats < 2 && budget > 0) begin
            step();
            budget--;
        end
        chk("midread_reached", dut_rbeats, 2);
        do_reset();
        clear_counts();
        start_read(4'($urandom), 8'd2);
        run_until_idle(30);
        check_counts("post_reset");

        // Longest burst
        clear_counts();
        rr_mode = 0;
        start_read(4'($urandom), 8'd255);
        run_until_idle(400);
        check_counts("read256");

        // Random concurrent traffic
        for (int t = 0; t < 16; t++) begin
            clear_counts();
            rr_mode = 2; br_rand = 1; w_rand = 1;
            b_stall = $urandom_range(0, 4);
            ln = 8'($urandom_range(0, 40));
            wl = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 3) != 0) start_read(4'($urandom), ln);
            if ($urandom_range(0, 3) != 0) start_write(4'($urandom), wl);
            run_until_idle(1000);
            check_counts("random");
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
